// File: rtl/glyph_renderer.sv
// Character-cell plotter: captures a glyph and its colours on start, then scans the
// cell one pixel per cycle onto registered x/y/colour/plot outputs for the VGA adapter.
module glyph_renderer #(
   parameter int GLYPH_W  = 8,
   parameter int GLYPH_H  = 16,
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int COLOUR_W = 3,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [GLYPH_W*GLYPH_H-1:0]  glyph_bits,
   input  logic [X_W-1:0]              origin_x,
   input  logic [Y_W-1:0]              origin_y,
   input  logic [COLOUR_W-1:0]         fg_colour,
   input  logic [COLOUR_W-1:0]         bg_colour,
   input  logic                        transparent,
   input  logic                        stall,
   output logic                        busy,
   output logic                        done,
   output logic [X_W-1:0]              x_out,
   output logic [Y_W-1:0]              y_out,
   output logic [COLOUR_W-1:0]         colour_out,
   output logic                        plot
);
   // state    | meaning
   // S_IDLE   | waiting for start; inputs captured on start
   // S_DRAW   | one pixel per unstalled cycle, row-major
   // S_FINISH | single-cycle done pulse, busy drops

   localparam int N  = GLYPH_W * GLYPH_H;
   localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
   localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
   localparam logic [CW-1:0]  COL_LAST = CW'(GLYPH_W - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(GLYPH_H - 1);
   localparam logic [X_W:0]   X_LIM    = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0]   Y_LIM    = (Y_W+1)'(SCREEN_H);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAW   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   logic [N-1:0]          r_bits;
   logic [X_W-1:0]        r_ox;
   logic [Y_W-1:0]        r_oy;
   logic [COLOUR_W-1:0]   r_fg, r_bg;
   logic                  r_transp;
   logic [CW-1:0]         r_col;
   logic [RW-1:0]         r_row;
   logic [X_W-1:0]        r_x;
   logic [Y_W-1:0]        r_y;
   logic [COLOUR_W-1:0]   r_colour;
   logic                  r_plot, r_busy, r_done;

   logic [X_W:0]          w_sum_x;
   logic [Y_W:0]          w_sum_y;
   logic                  w_bit, w_on, w_col_last, w_last;

   // Extra carry bit keeps wrapped coordinates off-screen.
   assign w_sum_x    = {1'b0, r_ox} + (X_W+1)'(r_col);
   assign w_sum_y    = {1'b0, r_oy} + (Y_W+1)'(r_row);
   assign w_on       = (w_sum_x < X_LIM) && (w_sum_y < Y_LIM);
   assign w_bit      = r_bits[N-1];
   assign w_col_last = (r_col == COL_LAST);
   assign w_last     = w_col_last && (r_row == ROW_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_DRAW;
         S_DRAW:   if (!stall && w_last) w_state_nxt = S_FINISH;
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bits   <= '0;
         r_ox     <= '0;
         r_oy     <= '0;
         r_fg     <= '0;
         r_bg     <= '0;
         r_transp <= 1'b0;
         r_col    <= '0;
         r_row    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_plot <= 1'b0;
               r_done <= 1'b0;
               if (start) begin
                  r_bits   <= glyph_bits;
                  r_ox     <= origin_x;
                  r_oy     <= origin_y;
                  r_fg     <= fg_colour;
                  r_bg     <= bg_colour;
                  r_transp <= transparent;
                  r_col    <= '0;
                  r_row    <= '0;
                  r_busy   <= 1'b1;
               end
            end
            S_DRAW: begin
               if (stall) begin
                  r_plot <= 1'b0;
               end else begin
                  r_x      <= w_sum_x[X_W-1:0];
                  r_y      <= w_sum_y[Y_W-1:0];
                  r_colour <= w_bit ? r_fg : r_bg;
                  r_plot   <= w_on && (w_bit || !r_transp);
                  // Current pixel always sits in the MSB of the shifted bitmap.
                  r_bits   <= r_bits << 1;
                  if (w_col_last) begin
                     r_col <= '0;
                     r_row <= r_row + RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            S_FINISH: begin
               r_plot <= 1'b0;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: begin
               r_plot <= 1'b0;
               r_done <= 1'b0;
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign x_out      = r_x;
   assign y_out      = r_y;
   assign colour_out = r_colour;
   assign plot       = r_plot;

endmodule

// File: tb/tb_glyph_renderer.sv
// Directed bench for glyph_renderer: default 8x16 build plus a 5x7 build on the same clock.
module tb_glyph_renderer;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, transparent, stall;
   logic [127:0]  glyph_bits;
   logic [8:0]    origin_x;
   logic [7:0]    origin_y;
   logic [2:0]    fg_colour, bg_colour;
   logic          busy, done, plot;
   logic [8:0]    x_out;
   logic [7:0]    y_out;
   logic [2:0]    colour_out;

   logic          s2_start;
   logic [34:0]   s2_glyph;
   logic          s2_busy, s2_done, s2_plot;
   logic [8:0]    s2_x;
   logic [7:0]    s2_y;
   logic [2:0]    s2_colour;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {int x; int y; int c; int cyc;} pix_t;
   pix_t obs[$];
   int   done_cyc, done_cnt, busy_pre;

   always #5 clk = ~clk;

   glyph_renderer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .glyph_bits(glyph_bits),
      .origin_x(origin_x), .origin_y(origin_y), .fg_colour(fg_colour),
      .bg_colour(bg_colour), .transparent(transparent), .stall(stall),
      .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
      .colour_out(colour_out), .plot(plot)
   );

   glyph_renderer #(.GLYPH_W(5), .GLYPH_H(7)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(s2_start), .glyph_bits(s2_glyph),
      .origin_x(9'd0), .origin_y(8'd0), .fg_colour(3'b110), .bg_colour(3'b001),
      .transparent(1'b0), .stall(1'b0),
      .busy(s2_busy), .done(s2_done), .x_out(s2_x), .y_out(s2_y),
      .colour_out(s2_colour), .plot(s2_plot)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Runs one render; optional mid-run stall, second start, or reset at a cycle index.
   task automatic run(input int ox, input int oy, input int fg, input int bg, input int tr,
                      input logic [127:0] g, input int stall_at, input int restart_at,
                      input int reset_at);
      obs.delete();
      done_cyc = 0; done_cnt = 0; busy_pre = -1;
      @(negedge clk);
      origin_x = 9'(ox); origin_y = 8'(oy); fg_colour = 3'(fg); bg_colour = 3'(bg);
      transparent = tr[0]; glyph_bits = g; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         if (plot) obs.push_back('{int'(x_out), int'(y_out), int'(colour_out), c});
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc = c;
               chk("busy_at_done", busy, 1'b0);
            end
         end
         if (done_cyc == 0 && !done) busy_pre = int'(busy);
         if (c == stall_at) stall = 1'b1;
         if (c == stall_at + 5) stall = 1'b0;
         if (c == restart_at) begin
            start = 1'b1; origin_x = 9'd100; origin_y = 8'd50;
            fg_colour = 3'b010; bg_colour = 3'b100; glyph_bits = '0; transparent = 1'b0;
         end
         if (c == restart_at + 1) start = 1'b0;
         if (c == reset_at) begin
            reset_n = 1'b0; #1;
            chk("rst_plot", plot, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_x", x_out, 9'd0);
            chk("rst_y", y_out, 8'd0);
            chk("rst_colour", colour_out, 3'd0);
            repeat (3) @(posedge clk);
            #1 chk("rst_no_done", done, 1'b0);
            @(negedge clk) reset_n = 1'b1;
            return;
         end
         if (done_cyc != 0 && c == done_cyc + 3) break;
      end
      if (done_cyc == 0) chk("done_timeout", 1'b0, 1'b1);
   endtask

   task automatic verify(input string nm, input int ox, input int oy, input int fg, input int bg,
                         input int tr, input logic [127:0] g, input int stall_at,
                         input int exp_plots, input int exp_done);
      pix_t ex[$];
      int x, y, b, n;
      for (int k = 0; k < 128; k++) begin
         x = (ox + k % 8) & 511;
         y = (oy + k / 8) & 255;
         b = int'(g[127-k]);
         if ((ox + k % 8) < 320 && (oy + k / 8) < 240 && (b == 1 || tr == 0))
            ex.push_back('{x, y, (b == 1) ? fg : bg,
                           k + 1 + ((stall_at >= 0 && k >= stall_at) ? 5 : 0)});
      end
      chk({nm, "_plots"}, obs.size(), exp_plots);
      chk({nm, "_done_cycle"}, done_cyc, exp_done);
      chk({nm, "_done_count"}, done_cnt, 1);
      chk({nm, "_busy_last"}, busy_pre, 1);
      n = (obs.size() < ex.size()) ? obs.size() : ex.size();
      for (int i = 0; i < n; i++) begin
         chk({nm, "_x"}, obs[i].x, ex[i].x);
         chk({nm, "_y"}, obs[i].y, ex[i].y);
         chk({nm, "_colour"}, obs[i].c, ex[i].c);
         chk({nm, "_cycle"}, obs[i].cyc, ex[i].cyc);
      end
   endtask

   initial begin
      logic [127:0] ones, msb, aa, nib;
      int cnt2, d2;
      ones = '1; msb = '0; msb[127] = 1'b1;
      aa = {16{8'hAA}}; nib = {16{8'h0F}};
      reset_n = 1'b0; start = 1'b0; stall = 1'b0; transparent = 1'b0;
      glyph_bits = '0; origin_x = '0; origin_y = '0; fg_colour = '0; bg_colour = '0;
      s2_start = 1'b0; s2_glyph = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_plot", plot, 1'b0);
      chk("reset_xy", {x_out, y_out}, 17'd0);
      chk("reset_colour", colour_out, 3'd0);
      @(negedge clk) reset_n = 1'b1;

      run(10, 20, 7, 1, 0, ones, -1, -1, -1);
      verify("ones", 10, 20, 7, 1, 0, ones, -1, 128, 129);

      run(10, 20, 7, 1, 1, msb, -1, -1, -1);
      verify("msb", 10, 20, 7, 1, 1, msb, -1, 1, 129);
      if (obs.size() > 0) chk("msb_first_xy", {obs[0].x, obs[0].y}, {32'd10, 32'd20});

      run(316, 236, 5, 2, 0, ones, -1, -1, -1);
      verify("clip", 316, 236, 5, 2, 0, ones, -1, 16, 129);

      run(10, 20, 7, 1, 0, ones, 40, -1, -1);
      verify("stall", 10, 20, 7, 1, 0, ones, 40, 128, 134);

      run(10, 20, 7, 1, 0, ones, -1, 50, -1);
      verify("restart", 10, 20, 7, 1, 0, ones, -1, 128, 129);

      run(10, 20, 7, 1, 0, ones, -1, -1, 60);
      run(0, 0, 5, 2, 1, aa, -1, -1, -1);
      verify("after_rst", 0, 0, 5, 2, 1, aa, -1, 64, 129);

      run(300, 0, 6, 3, 0, nib, -1, -1, -1);
      verify("bg_mix", 300, 0, 6, 3, 0, nib, -1, 128, 129);

      // 5x7 build: expect 35 plots in row-major order, done 36 cycles after start.
      cnt2 = 0; d2 = 0;
      @(negedge clk) s2_start = 1'b1;
      @(posedge clk); #1 s2_start = 1'b0;
      for (int c = 1; c <= 100 && d2 == 0; c++) begin
         @(posedge clk); #1;
         if (s2_plot) begin
            chk("g57_x", s2_x, 9'(cnt2 % 5));
            chk("g57_y", s2_y, 8'(cnt2 / 5));
            chk("g57_colour", s2_colour, 3'b110);
            cnt2++;
         end
         if (s2_done) d2 = c;
      end
      chk("g57_plots", cnt2, 35);
      chk("g57_done_cycle", d2, 36);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
Parametrised character-cell plotter. It sits between the keyboard/char-decoder path and vga_adapter. On a start pulse it captures a glyph bitmap, origin and colours, then scans the cell one pixel per cycle, driving x/y/colour/plot into the VGA adapter. Over the fixed 8x8 FSM/datapath pair it adds configurable cell size, foreground/background colours, transparent mode, screen-edge clipping, a stall input and a busy/done handshake.

Parameters:
GLYPH_W, 8, cell width in pixels (>=1)
GLYPH_H, 16, cell height in pixels (>=1)
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
COLOUR_W, 3, colour width
SCREEN_W, 320, visible columns; pixels with x >= SCREEN_W are clipped
SCREEN_H, 240, visible rows; pixels with y >= SCREEN_H are clipped

Ports:
clk  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request a render; sampled only in IDLE
glyph_bits  in  GLYPH_W*GLYPH_H  bitmap; MSB = top-left pixel, row-major
origin_x  in  X_W  top-left x of cell
origin_y  in  Y_W  top-left y of cell
fg_colour  in  COLOUR_W  colour for set bits
bg_colour  in  COLOUR_W  colour for clear bits
transparent  in  1  1 = clear bits are not plotted
stall  in  1  1 = freeze the scan; the VGA port is busy
busy  out  1  render in progress
done  out  1  one-cycle pulse after the last pixel
x_out  out  X_W  pixel x
y_out  out  Y_W  pixel y
colour_out  out  COLOUR_W  pixel colour
plot  out  1  write strobe for x_out/y_out/colour_out

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, plot=0, x_out=0, y_out=0, colour_out=0; counters=0. Asserting reset mid-render aborts it with no done pulse. Resuming needs a new start.
- States: IDLE, DRAW, FINISH.
- IDLE:
  - start=1 at an edge captures glyph_bits, origin_x, origin_y, fg_colour, bg_colour and transparent into internal registers.
  - At the same edge: col=0, row=0, busy=1, go to DRAW.
  - Later input changes do not affect the render in progress.
- DRAW: each edge with stall=0 emits pixel (row, col) on registered outputs and advances the scan.
  - Pixel bit index = GLYPH_W*GLYPH_H-1 - (row*GLYPH_W + col).
  - x_out = origin_x + col, truncated to X_W. y_out = origin_y + row, truncated to Y_W.
  - Clip test uses the full-width sums (X_W+1 and Y_W+1 bits), so wrap-around is always clipped.
  - colour_out = fg_colour if bit=1, else bg_colour.
  - plot=1 iff the pixel is on-screen AND (bit=1 OR transparent=0). Otherwise plot=0, but the scan still advances one pixel per cycle.
  - Scan order: col increments; at col=GLYPH_W-1, col wraps to 0 and row increments.
  - After the pixel (GLYPH_H-1, GLYPH_W-1) is emitted, go to FINISH.
- stall=1 in DRAW: plot=0 on the next edge; counters and the other outputs hold. The same pixel is emitted on the first edge with stall=0. No pixel is skipped or duplicated.
- FINISH: lasts one cycle. plot=0, done=1, busy=0 at its edge, then IDLE. done is 0 in every other cycle.
- Timing: start sampled at edge E0 → busy=1 after E0. Pixel k (k=0..N-1, N=GLYPH_W*GLYPH_H) is presented after edge E0+1+k+(stall cycles).
  - done=1 after edge E0+N+1+stalls.
  - Minimum restart: start sampled in the cycle done is high is ignored, because the block is still FINISH at that edge. start is accepted at the next edge in IDLE.
- start while busy or in FINISH: ignored; no effect on captured data.
- Outputs are fully registered; no combinational input-to-output paths.

Test Plan:
- Reset high, origin=(10,20), fg=3'b111, bg=3'b001, transparent=0, glyph all-ones (default 8x16), start pulse:
  - exactly 128 plots, x 10..17 and y 20..35 in row-major order, all colour 111.
  - done pulses once, 129 cycles after start.
- Glyph with only the MSB set, transparent=1:
  - exactly one plot at (origin_x, origin_y) with fg colour; busy stays high for 128 cycles.
- origin=(316,236), all-ones glyph:
  - plots only for x 316..319 and y 236..239 (16 plots); the remaining 112 cycles have plot=0.
  - done timing is unchanged (129 cycles).
- stall held high for 5 cycles at pixel 40:
  - plot=0 during the stall; pixel 40 is emitted once afterwards.
  - done arrives 134 cycles after start; the pixel sequence is identical to the unstalled run.
- Second start pulse at pixel 50, with different origin and colour inputs:
  - ignored; the remaining pixels use the first captured values; only one done.
- reset_n low at pixel 60 → all outputs 0 immediately with no done; a fresh start renders the full 128 pixels correctly.
- GLYPH_W=5, GLYPH_H=7 build, all-ones glyph at (0,0) → 35 plots covering x 0..4, y 0..6; done 36 cycles after start.
